// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write register file with issue scoreboard and a valid/ready debug dump engine.
// Optional write-to-read forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                dbg_start,
  output logic                dbg_valid,
  input  logic                dbg_ready,
  output logic [AW-1:0]       dbg_idx,
  output logic [XLEN-1:0]     dbg_data,
  output logic                dbg_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } dump_state_e;

  logic [NREGS-1:0][XLEN-1:0] regs_r;
  logic [NREGS-1:0]           busy_r;
  dump_state_e                state_r, state_nxt_s;
  logic [AW-1:0]              idx_r, idx_nxt_s;
  logic                       done_r, done_nxt_s;

  // Array and scoreboard update; later ports win, a same-cycle reservation beats a write clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_r <= '0;
      busy_r <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) begin
          regs_r[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          busy_r[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (rsv_en) begin
        busy_r[rsv_addr] <= 1'b1;
      end
      regs_r[0] <= '0;
      busy_r[0] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;

    assign addr_s = rd_addr[k*AW +: AW];

    // Combinational read port, optionally forwarding in-flight write data
    always_comb begin
      data_s = regs_r[addr_s];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        data_s = (wr_en[w] && (wr_addr[w*AW +: AW] == addr_s)) ? wr_data[w*XLEN +: XLEN] : data_s;
      end
`endif
      data_s = (addr_s == '0) ? '0 : data_s;
    end

    assign rd_data[k*XLEN +: XLEN] = data_s;
    assign rd_busy[k]              = busy_r[addr_s];
  end

  // Dump FSM state, beat index and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Dump FSM next-state logic; dbg_start is deliberately ignored while a dump runs
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (dbg_start) begin
          state_nxt_s = S_RUN;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (dbg_ready) begin
          if (idx_r == AW'(NREGS - 1)) begin
            state_nxt_s = S_IDLE;
            idx_nxt_s   = '0;
            done_nxt_s  = 1'b1;
          end else begin
            idx_nxt_s = idx_r + AW'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        idx_nxt_s   = '0;
      end
    endcase
  end

  assign dbg_valid = (state_r == S_RUN);
  assign dbg_idx   = idx_r;
  assign dbg_done  = done_r;
  assign dbg_data  = dbg_valid ? regs_r[idx_r] : '0;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 32-bit core, the successor to the fixed 2R1W file. It provides NRD asynchronous read ports, NWR synchronous write ports with defined same-address priority, and a per-register scoreboard (busy bits) for the issue stage. It also includes a sequential debug-dump engine that streams every register over a valid/ready port. It sits between decode/issue (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers, power of two ≥ 4. AW = log2(NREGS) is derived, not a parameter.
- NRD, 2: read ports, 1..4.
- NWR, 1: write ports, 1..2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  scoreboard busy bit of each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- dbg_start  in  1  start a full register dump.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  consumer accepts the dump beat.
- dbg_idx  out  AW  register index of the current beat.
- dbg_data  out  XLEN  register value of the current beat.
- dbg_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- R0 is hardwired to zero. Writes to R0 are dropped, reads of R0 return 0, and R0 is never busy.
- Writes commit at the rising edge. If several ports write the same address, the highest-index port wins.
- Reads are combinational from the array. With bypass enabled (see Configuration), a read whose address matches an active write returns that write's data, highest-index port first.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - Any committed write clears busy[wr_addr].
  - Simultaneous reserve and write to the same address leaves busy set (the new reservation wins).
  - rd_busy[k] reads the registered busy bit of rd_addr[k] combinationally.
- Dump FSM states IDLE and RUN:
  - IDLE→RUN on dbg_start; dbg_idx resets to 0.
  - In RUN, dbg_valid is 1 and dbg_data is the array value at dbg_idx (no bypass). The R0 beat is 0.
  - A beat is accepted when dbg_valid && dbg_ready. On acceptance, dbg_idx increments.
  - When the beat at NREGS-1 is accepted: transition to IDLE, dbg_done pulses, and dbg_idx returns to 0.
  - dbg_start is ignored in RUN.
  - Writes during a stalled beat may change dbg_data. The consumer samples dbg_data only at acceptance.

## Timing
- Reset values:
  - all registers 0, all busy bits 0, FSM in IDLE;
  - dbg_valid=0, dbg_done=0, dbg_idx=0, dbg_data=0;
  - rd_data and rd_busy equal 0 for every port.
- Write latency: 1 cycle to the array. With bypass, read-after-write in the same cycle has 0 latency.
- Reserve latency: busy is visible on rd_busy the cycle after rsv_en.
- Dump length: minimum NREGS cycles from the first dbg_valid to the last acceptance, with dbg_ready held high. dbg_done is asserted in the cycle after the final acceptance.
- Reset asserted mid-dump or mid-write: everything returns to the reset values immediately. No partial write commits.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is active, as described in Operation.
- Undefined: reads see the array only. A same-cycle write becomes visible on the next cycle. This removes the forwarding muxes from the read path.

## Test plan
- Reset, then read all ports at R5 → rd_data=0 and rd_busy=0 on every port. Write R0=0xDEADBEEF → R0 still reads 0.
- NWR=2: both ports write R7 in the same cycle (0x11111111 on port 0, 0x22222222 on port 1) → R7=0x22222222 the next cycle. With the bypass macro defined, rd_data shows 0x22222222 in the same cycle; without it, the old value.
- rsv_en on R3 → rd_busy=1 the next cycle. Write R3=0xA5A5A5A5 → busy=0 the cycle after. Reserve and write R3 in the same cycle → busy stays 1.
- Load R1..R31 with 0x1000+index, pulse dbg_start with dbg_ready=1 → 32 beats, idx 0..31, data 0 then 0x1001..0x101F, then a single dbg_done pulse.
- During a dump, hold dbg_ready=0 for 3 cycles at idx 4 → dbg_idx stays 4 and dbg_valid stays 1. A dbg_start pulse in RUN → no restart.
- Assert rst_n low at dump beat 10 → dbg_valid=0 and dbg_idx=0 immediately, and all registers read 0.
